// File: rtl/clock_div_monitor.sv
// Divided-clock monitor: measures period and high time of mon_clk in clock_in cycles,
// tracks lock on the expected ratio, and counts bad periods and stuck-clock timeouts.
module clock_div_monitor #(
  parameter int DIV_RATIO  = 3,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DIV_VAL   = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HI_MAX    = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             s0_q, s0_d, s1_q, s1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hc_q, hc_d;
  logic [RUN_W-1:0] lock_run_q, lock_run_d;
  logic [CNT_W-1:0] period_q, period_d, high_cnt_q, high_cnt_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d, stuck_q, stuck_d;
  logic             to_seen_q, to_seen_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             rise, good, timeout, err_ev;
  logic [CNT_W-1:0] cnt_inc, hc_inc, s0_ext;

  always_comb begin
    s0_d           = mon_clk;
    s1_d           = s0_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    hc_d           = hc_q;
    lock_run_d     = lock_run_q;
    period_d       = period_q;
    high_cnt_d     = high_cnt_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    stuck_d        = stuck_q;
    to_seen_d      = to_seen_q;
    err_ev         = 1'b0;

    rise    = s0_q & ~s1_q;
    s0_ext  = {{(CNT_W-1){1'b0}}, s0_q};
    cnt_inc = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CNT_ONE;
    hc_inc  = (hc_q == TO_VAL) ? hc_q : hc_q + s0_ext;
    good    = (cnt_q == DIV_VAL) && (hc_q != '0) && (hc_q <= HI_MAX);
    // A timeout fires once; to_seen_q blocks recounting while cnt stays saturated.
    timeout = !rise && (cnt_q == TO_VAL) && !to_seen_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      hc_d       = '0;
      lock_run_d = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b0;
      to_seen_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQUIRE;
    end else begin
      cnt_d = rise ? CNT_ONE : cnt_inc;
      hc_d  = rise ? s0_ext : hc_inc;
      if (rise) begin
        stuck_d   = 1'b0;
        to_seen_d = 1'b0;
        if (state_q == ST_ACQUIRE) begin
          state_d = ST_MEASURE;
        end else begin
          period_d       = cnt_q;
          high_cnt_d     = hc_q;
          period_valid_d = 1'b1;
          if (good) begin
            if (int'(lock_run_q) < LOCK_COUNT) lock_run_d = lock_run_q + 1'b1;
            if (int'(lock_run_q) + 1 >= LOCK_COUNT) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            lock_run_d = '0;
            locked_d   = 1'b0;
            err_ev     = 1'b1;
            state_d    = ST_MEASURE;
          end
        end
      end else if (timeout) begin
        to_seen_d  = 1'b1;
        stuck_d    = 1'b1;
        locked_d   = 1'b0;
        lock_run_d = '0;
        err_ev     = 1'b1;
        state_d    = ST_ACQUIRE;
      end
    end

    if (clr_err)                          err_cnt_d = err_ev ? 8'd1 : 8'd0;
    else if (err_ev && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    else                                   err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      cnt_q          <= '0;
      hc_q           <= '0;
      lock_run_q     <= '0;
      period_q       <= '0;
      high_cnt_q     <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
      to_seen_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      cnt_q          <= cnt_d;
      hc_q           <= hc_d;
      lock_run_q     <= lock_run_d;
      period_q       <= period_d;
      high_cnt_q     <= high_cnt_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
      to_seen_q      <= to_seen_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign period       = period_q;
  assign high_cnt     = high_cnt_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Bench for clock_div_monitor: directed and random mon_clk waveforms checked against a
// timestamp-based model (edge times of rises, window sums of high samples).
module tb_clock_div_monitor;
  localparam int DIV_RATIO  = 3;
  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 16;

  logic             clock_in = 1'b0;
  logic             reset, mon_clk, enable, clr_err;
  logic [CNT_W-1:0] period, high_cnt;
  logic             period_valid, locked, stuck;
  logic [7:0]       err_cnt;

  int checks   = 0;
  int failures = 0;

  clock_div_monitor #(
    .DIV_RATIO(DIV_RATIO), .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_in(clock_in), .reset(reset), .mon_clk(mon_clk), .enable(enable),
    .clr_err(clr_err), .period(period), .high_cnt(high_cnt),
    .period_valid(period_valid), .locked(locked), .stuck(stuck), .err_cnt(err_cnt)
  );

  // clock block
  always #5 clock_in = ~clock_in;

  // reference model: hist[e] is the mon_clk level seen at clock edge e
  bit hist[0:16383];
  int e_cnt   = 0;
  int m_start = 0;   // edges before this read as 0 (sampler cleared by reset)
  int m_mode, m_base, m_run, m_period, m_high, m_err;
  bit m_pv, m_locked, m_stuck, m_to;

  function automatic bit smp(input int i);
    return (i < m_start) ? 1'b0 : hist[i];
  endfunction

  task automatic model_reset(input int next_edge);
    m_mode = 0; m_base = 0; m_run = 0; m_period = 0; m_high = 0; m_err = 0;
    m_pv = 0; m_locked = 0; m_stuck = 0; m_to = 0;
    m_start = next_edge;
  endtask

  task automatic model_edge(input int e, input bit en, input bit clr);
    bit rise, err_ev;
    int age, hcount;
    rise   = smp(e-1) && !smp(e-2);
    age    = (m_mode == 0) ? 0 : ((e - 1 - m_base) < TIMEOUT ? (e - 1 - m_base) : TIMEOUT);
    err_ev = 0;
    m_pv   = 0;
    if (!en) begin
      m_mode = 0; m_run = 0; m_locked = 0; m_stuck = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_base = e; m_to = 0;
    end else if (rise) begin
      m_stuck = 0; m_to = 0;
      if (m_mode == 1) m_mode = 2;
      else begin
        hcount = 0;
        for (int i = m_base; i <= e - 2; i++) hcount += int'(smp(i));
        m_period = age; m_high = hcount; m_pv = 1;
        if (age == DIV_RATIO && hcount >= 1 && hcount <= DIV_RATIO - 1) begin
          m_run++;
          if (m_run >= LOCK_COUNT) m_locked = 1;
        end else begin
          m_run = 0; m_locked = 0; err_ev = 1;
        end
      end
      m_base = e - 1;
    end else if (age == TIMEOUT && !m_to) begin
      m_to = 1; m_stuck = 1; m_locked = 0; m_run = 0; err_ev = 1; m_mode = 1;
    end
    if (clr)                          m_err = err_ev ? 1 : 0;
    else if (err_ev && m_err < 255)   m_err++;
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    bit r, en, c;
    hist[e_cnt] = mon_clk; r = reset; en = enable; c = clr_err;
    @(posedge clock_in);
    if (r) model_reset(e_cnt + 1);
    else   model_edge(e_cnt, en, c);
    e_cnt++;
    @(negedge clock_in);
    chk("period_valid", {31'd0, period_valid}, {31'd0, m_pv});
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("stuck", {31'd0, stuck}, {31'd0, m_stuck});
    chk("err_cnt", {24'd0, err_cnt}, m_err);
    chk("period", {24'd0, period}, m_period);
    chk("high_cnt", {24'd0, high_cnt}, m_high);
  endtask

  task automatic drive(input bit m, input bit c);
    mon_clk = m; clr_err = c;
    step();
  endtask

  task automatic pattern(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) drive(1'b0, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, {24'd0, period}, 0);
    chk({tag, "_high"}, {24'd0, high_cnt}, 0);
    chk({tag, "_pv"}, {31'd0, period_valid}, 0);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_stuck"}, {31'd0, stuck}, 0);
    chk({tag, "_err"}, {24'd0, err_cnt}, 0);
  endtask

  initial begin
    int pv_seen;
    reset = 1'b1; mon_clk = 1'b0; enable = 1'b0; clr_err = 1'b0;
    model_reset(0);
    repeat (2) step();
    chk_all_zero("reset");
    reset = 1'b0;
    enable = 1'b1;

    // divide-by-3 waveform, expected to lock with no errors
    pattern(2, 1, 8);
    chk("t1_locked", {31'd0, locked}, 1);
    chk("t1_err", {24'd0, err_cnt}, 0);

    // one stretched period of 5, then recovery
    pattern(1, 2, 6);
    pattern(1, 4, 1);
    pattern(1, 2, 6);
    chk("t2_err", {24'd0, err_cnt}, 1);
    chk("t2_relock", {31'd0, locked}, 1);

    // stuck low, then restart
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);
    chk("t3_stuck", {31'd0, stuck}, 1);
    chk("t3_locked", {31'd0, locked}, 0);
    chk("t3_err", {24'd0, err_cnt}, 2);
    pattern(1, 2, 6);
    chk("t3_unstuck", {31'd0, stuck}, 0);
    chk("t3_relock", {31'd0, locked}, 1);

    // too much high time: bad periods, no lock
    pattern(3, 1, 3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    pattern(1, 2, 1);
    chk("t4_locked", {31'd0, locked}, 0);

    // random waveforms with occasional enable drops and clears
    for (int n = 0; n < 60; n++) begin
      int hi, lo;
      hi = $urandom_range(1, 3);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) enable = 1'b0;
      for (int i = 0; i < hi; i++) drive(1'b1, $urandom_range(0, 15) == 0);
      enable = 1'b1;
      for (int i = 0; i < lo; i++) drive(1'b0, $urandom_range(0, 15) == 0);
    end

    // 300 timeouts to saturate err_cnt
    for (int n = 0; n < 300; n++) begin
      enable = 1'b0;
      drive(1'b0, 1'b0);
      enable = 1'b1;
      for (int i = 0; i < TIMEOUT + 2; i++) drive(1'b0, 1'b0);
    end
    chk("t5_sat", {24'd0, err_cnt}, 255);
    drive(1'b0, 1'b1);
    chk("t5_clear", {24'd0, err_cnt}, 0);
    pattern(1, 2, 3);
    pattern(1, 5, 1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    chk("t5_clr_and_err", {24'd0, err_cnt}, 1);
    clr_err = 1'b0;

    // async reset mid-period while locked
    pattern(2, 1, 6);
    chk("t6_locked", {31'd0, locked}, 1);
    drive(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    reset = 1'b0;
    pv_seen = 0;
    pattern(2, 1, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
